// File: rtl/mem_xfer_pkg.sv
// Shared constants for the MemoryA -> MemoryB transfer controller.
package mem_xfer_pkg;

    localparam int unsigned AddrWDefault = 2;
    localparam int unsigned DataWDefault = 8;
    localparam int unsigned DepthDefault = 4;

    // 3-bit state encoding; StIdle must stay 0 so reset lands in idle.
    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StRdA   = 3'd1;
    localparam logic [2:0] StSetup = 3'd2;
    localparam logic [2:0] StWrB   = 3'd3;
    localparam logic [2:0] StHold  = 3'd4;
    localparam logic [2:0] StVfRd  = 3'd5;
    localparam logic [2:0] StDone  = 3'd6;

endpackage

// File: rtl/mem_xfer_ctrl_if.sv
// Host handshake and two-memory bus seen by the transfer controller.
interface mem_xfer_ctrl_if #(
    parameter int unsigned ADDR_W = mem_xfer_pkg::AddrWDefault,
    parameter int unsigned DATA_W = mem_xfer_pkg::DataWDefault
);
    logic              Start;
    logic              Verify;
    logic [ADDR_W-1:0] AddrA;
    logic [DATA_W-1:0] DataOutA;
    logic [ADDR_W-1:0] AddrB;
    logic              WEB;
    logic [DATA_W-1:0] DataInB;
    logic [DATA_W-1:0] DataOutB;
    logic              Busy;
    logic              Done;
    logic              Error;
    logic [ADDR_W-1:0] ErrAddr;
    logic [ADDR_W:0]   XferCount;

    modport master (
        input  Start, Verify, DataOutA, DataOutB,
        output AddrA, AddrB, WEB, DataInB, Busy, Done, Error, ErrAddr, XferCount
    );

    modport slave (
        output Start, Verify, DataOutA, DataOutB,
        input  AddrA, AddrB, WEB, DataInB, Busy, Done, Error, ErrAddr, XferCount
    );

endinterface

// File: rtl/mem_xfer_ctrl.sv
// Copies MemoryA into MemoryB word by word with a guarded one-cycle write strobe,
// optionally reading MemoryB back and flagging the first mismatching address.
module mem_xfer_ctrl
    import mem_xfer_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrWDefault,
    parameter int unsigned DATA_W = DataWDefault,
    parameter int unsigned DEPTH  = DepthDefault
) (
    input logic             clk,
    input logic             rst_n,
    mem_xfer_ctrl_if.master bus
);

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

    logic [2:0]        stateQ, stateD;
    logic [ADDR_W-1:0] idxQ, idxD;
    logic [ADDR_W-1:0] addrQ, addrD;
    logic [DATA_W-1:0] dataQ, dataD;
    logic              webQ, webD;
    logic              busyQ, busyD;
    logic              doneQ, doneD;
    logic              errorQ, errorD;
    logic [ADDR_W-1:0] errAddrQ, errAddrD;
    logic [ADDR_W:0]   cntQ, cntD;
    logic              verifyQ, verifyD;

    always_comb begin
        stateD   = stateQ;
        idxD     = idxQ;
        addrD    = addrQ;
        dataD    = dataQ;
        webD     = 1'b0;
        busyD    = busyQ;
        doneD    = 1'b0;
        errorD   = errorQ;
        errAddrD = errAddrQ;
        cntD     = cntQ;
        verifyD  = verifyQ;
        unique case (stateQ)
            StIdle: begin
                if (bus.Start) begin
                    verifyD  = bus.Verify;
                    errorD   = 1'b0;
                    errAddrD = '0;
                    cntD     = '0;
                    idxD     = '0;
                    addrD    = '0;
                    busyD    = 1'b1;
                    stateD   = StRdA;
                end
            end
            StRdA: begin
                dataD  = bus.DataOutA;
                stateD = StSetup;
            end
            StSetup: begin
                webD   = 1'b1;
                stateD = StWrB;
            end
            StWrB: begin
                cntD   = cntQ + 1'b1;
                stateD = StHold;
            end
            StHold: begin
                // Address and data stay put here so they outlive the strobe by one edge.
                if (idxQ == LastIdx) begin
                    if (verifyQ) begin
                        idxD   = '0;
                        addrD  = '0;
                        stateD = StVfRd;
                    end else begin
                        doneD  = 1'b1;
                        stateD = StDone;
                    end
                end else begin
                    idxD   = idxQ + 1'b1;
                    addrD  = idxQ + 1'b1;
                    stateD = StRdA;
                end
            end
            StVfRd: begin
                if ((bus.DataOutB != bus.DataOutA) && !errorQ) begin
                    errorD   = 1'b1;
                    errAddrD = idxQ;
                end
                if (idxQ == LastIdx) begin
                    doneD  = 1'b1;
                    stateD = StDone;
                end else begin
                    idxD  = idxQ + 1'b1;
                    addrD = idxQ + 1'b1;
                end
            end
            StDone: begin
                busyD  = 1'b0;
                stateD = StIdle;
            end
            default: begin
                busyD  = 1'b0;
                stateD = StIdle;
            end
        endcase
    end

    // Every output is a flop with async clear, so WEB drops the moment rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ   <= StIdle;
            idxQ     <= '0;
            addrQ    <= '0;
            dataQ    <= '0;
            webQ     <= 1'b0;
            busyQ    <= 1'b0;
            doneQ    <= 1'b0;
            errorQ   <= 1'b0;
            errAddrQ <= '0;
            cntQ     <= '0;
            verifyQ  <= 1'b0;
        end else begin
            stateQ   <= stateD;
            idxQ     <= idxD;
            addrQ    <= addrD;
            dataQ    <= dataD;
            webQ     <= webD;
            busyQ    <= busyD;
            doneQ    <= doneD;
            errorQ   <= errorD;
            errAddrQ <= errAddrD;
            cntQ     <= cntD;
            verifyQ  <= verifyD;
        end
    end

    assign bus.AddrA     = addrQ;
    assign bus.AddrB     = addrQ;
    assign bus.WEB       = webQ;
    assign bus.DataInB   = dataQ;
    assign bus.Busy      = busyQ;
    assign bus.Done      = doneQ;
    assign bus.Error     = errorQ;
    assign bus.ErrAddr   = errAddrQ;
    assign bus.XferCount = cntQ;

endmodule
